// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI AR/R channel among NREQ requesters, one read outstanding.
// Three cycles minimum per single-beat read; AR held until arready, no new grant until the R burst ends.
module axi_rd_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*3-1:0] req_type,
  output logic [NREQ-1:0]   req_rdy,
  output logic [NREQ-1:0]   ret_valid,
  output logic              ret_last,
  output logic [31:0]       ret_data,
  input  logic              wr_busy,
  input  logic [31:0]       wr_addr,
  output logic [IDW-1:0]    axi_arid,
  output logic [31:0]       axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic [1:0]        axi_arlock,
  output logic [3:0]        axi_arcache,
  output logic [2:0]        axi_arprot,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [31:0]       axi_rdata,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt;
  logic [7:0]      cnt;
  logic [NREQ-1:0] elig;
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [31:0]     sel_addr;
  logic [2:0]      sel_type;
  int              cand;
  logic            unused_wr_low;

  assign axi_arburst   = 2'b01;
  assign axi_arlock    = 2'b00;
  assign axi_arcache   = 4'b0000;
  assign axi_arprot    = 3'b000;
  assign unused_wr_low = ^wr_addr[3:0];

  function automatic logic [7:0] len_of(input logic [2:0] t);
    case (t)
      3'b100:  return 8'd3;
      3'b111:  return 8'd7;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t)
      3'b000:  return 3'd0;
      3'b001:  return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  // A read hitting the same 16-byte line as the in-flight write must wait
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] & ~(wr_busy & (req_addr[32*i+4 +: 28] == wr_addr[31:4]));
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!sel_found && elig[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_type = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_addr = req_addr[32*i +: 32];
        sel_type = req_type[3*i +: 3];
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (aresetn && state == S_IDLE && sel_found) req_rdy[sel_idx] = 1'b1;
  end

  always_comb begin
    ret_valid = '0;
    if (state == S_R) ret_valid[gnt] = axi_rvalid;
  end

  assign ret_last = (state == S_R) & axi_rvalid & axi_rlast;
  assign ret_data = axi_rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      gnt         <= '0;
      cnt         <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arid    <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            gnt         <= sel_idx;
            rr_ptr      <= (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + 1'b1;
            axi_araddr  <= sel_addr;
            axi_arid    <= IDW'(sel_idx);
            axi_arlen   <= len_of(sel_type);
            axi_arsize  <= size_of(sel_type);
            axi_arvalid <= 1'b1;
            state       <= S_AR;
          end
        end
        S_AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            cnt         <= axi_arlen;
            state       <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid) begin
            cnt <= cnt - 8'd1;
            // rlast always ends the burst, even if the beat count disagrees
            if (axi_rlast) begin
              axi_rready <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized reads against a reference model.
module tb_axi_rd_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ*3-1:0] req_type = '0;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ-1:0]   ret_valid;
  logic              ret_last;
  logic [31:0]       ret_data;
  logic              wr_busy = 1'b0;
  logic [31:0]       wr_addr = '0;
  logic [IDW-1:0]    axi_arid;
  logic [31:0]       axi_araddr;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic [1:0]        axi_arlock;
  logic [3:0]        axi_arcache;
  logic [2:0]        axi_arprot;
  logic              axi_arvalid;
  logic              axi_arready = 1'b0;
  logic [31:0]       axi_rdata = '0;
  logic              axi_rlast = 1'b0;
  logic              axi_rvalid = 1'b0;
  logic              axi_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type), .req_rdy(req_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  function automatic logic [7:0] m_len(input logic [2:0] t);
    if (t == 3'b100) return 8'd3;
    if (t == 3'b111) return 8'd7;
    return 8'd0;
  endfunction

  function automatic logic [2:0] m_size(input logic [2:0] t);
    if (t == 3'b000) return 3'd0;
    if (t == 3'b001) return 3'd1;
    return 3'd2;
  endfunction

  // Expected grant: first requester at or after the pointer that is valid and not on the write's line
  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ] &&
          !(wr_busy && req_addr[32*((m_ptr + k) % NREQ) + 4 +: 28] == wr_addr[31:4]))
        return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [2:0] t);
    req_addr[32*i +: 32] = a;
    req_type[3*i +: 3]   = t;
  endtask

  // Plays the AXI slave for one read; entered and left at negedge+1
  task automatic run_txn(input int ar_delay, input int nbeats, input int gap_max, input bit drop, input bit flip_wr,
                         output int o_gnt, output logic [31:0] o_addr, output logic [IDW-1:0] o_id,
                         output logic [7:0] o_len, output logic [2:0] o_size, output int o_beats,
                         output int o_lastcnt, output int o_lastpos, output int o_bad, output int o_wait);
    logic [31:0]     d;
    logic [NREQ-1:0] exp_rv;
    o_gnt = -1; o_addr = '0; o_id = '0; o_len = '0; o_size = '0;
    o_beats = 0; o_lastcnt = 0; o_lastpos = 0; o_bad = 0; o_wait = 0;
    while (o_gnt < 0 && o_wait < 40) begin
      #1;
      if (req_rdy != '0) begin
        if ($countones(req_rdy) != 1) o_bad++;
        for (int i = 0; i < NREQ; i++) if (req_rdy[i]) o_gnt = i;
      end else begin
        o_wait++;
        @(negedge aclk);
      end
    end
    if (o_gnt < 0) return;
    exp_rv = '0;
    exp_rv[o_gnt] = 1'b1;
    @(negedge aclk); #1;
    if (drop) req_valid[o_gnt] = 1'b0;
    if (flip_wr) wr_busy = ~wr_busy;
    if (axi_arvalid !== 1'b1) o_bad++;
    o_addr = axi_araddr; o_id = axi_arid; o_len = axi_arlen; o_size = axi_arsize;
    repeat (ar_delay) begin
      @(negedge aclk); #1;
      if (axi_arvalid !== 1'b1 || axi_araddr !== o_addr || axi_arid !== o_id ||
          axi_arlen !== o_len || axi_arsize !== o_size || req_rdy !== '0) o_bad++;
    end
    axi_arready = 1'b1;
    @(negedge aclk); #1;
    axi_arready = 1'b0;
    if (axi_arvalid !== 1'b0 || axi_rready !== 1'b1) o_bad++;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        axi_rvalid = 1'b0; #1;
        if (ret_valid !== '0 || ret_last !== 1'b0 || req_rdy !== '0 || axi_rready !== 1'b1) o_bad++;
        @(negedge aclk); #1;
      end
      d = $urandom;
      axi_rvalid = 1'b1; axi_rdata = d; axi_rlast = (b == nbeats - 1); #1;
      if (ret_valid === exp_rv) o_beats++; else o_bad++;
      if (ret_last === 1'b1) begin o_lastcnt++; o_lastpos = b + 1; end
      if (ret_data !== d || req_rdy !== '0 || axi_rready !== 1'b1) o_bad++;
      @(negedge aclk); #1;
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; req_valid = '1;
    repeat (3) @(negedge aclk);
    #1;
    n_checks++; if (axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got=%b want=0", axi_arvalid); end
    n_checks++; if (axi_rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready got=%b want=0", axi_rready); end
    n_checks++; if (req_rdy !== '0) begin n_fail++; $display("FAIL rst_req_rdy got=%b want=0", req_rdy); end
    n_checks++; if (ret_valid !== '0 || ret_last !== 1'b0) begin n_fail++; $display("FAIL rst_ret got=%b/%b want=0/0", ret_valid, ret_last); end
    n_checks++; if (axi_araddr !== '0 || axi_arid !== '0) begin n_fail++; $display("FAIL rst_addr_id got=%h/%h want=0/0", axi_araddr, axi_arid); end
    n_checks++; if (axi_arlen !== '0 || axi_arsize !== '0) begin n_fail++; $display("FAIL rst_len_size got=%h/%h want=0/0", axi_arlen, axi_arsize); end
    n_checks++; if ({axi_arburst, axi_arlock, axi_arcache, axi_arprot} !== 11'b01_00_0000_000) begin
      n_fail++; $display("FAIL const_fields got=%b want=01000000000", {axi_arburst, axi_arlock, axi_arcache, axi_arprot}); end
    req_valid = '0;
    aresetn = 1'b1;
    m_ptr = 0;
    @(negedge aclk); #1;
  endtask

  task automatic test_single_word();
    int g, beats, lc, lp, bad, w; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    set_req(0, 32'h1000, 3'b010); req_valid = 3'b001;
    run_txn(0, 1, 0, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== 0 || id !== 4'd0) begin n_fail++; $display("FAIL single_gnt got=%0d id=%0d want=0", g, id); end
    n_checks++; if (a !== 32'h1000) begin n_fail++; $display("FAIL single_addr got=%h want=1000", a); end
    n_checks++; if (len !== 8'd0 || sz !== 3'd2) begin n_fail++; $display("FAIL single_len_size got=%0d/%0d want=0/2", len, sz); end
    n_checks++; if (beats !== 1 || lc !== 1 || bad !== 0) begin n_fail++; $display("FAIL single_ret beats=%0d last=%0d bad=%0d want=1/1/0", beats, lc, bad); end
    m_ptr = 1;
  endtask

  task automatic test_burst8();
    int g, beats, lc, lp, bad, w; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    set_req(1, 32'h2000, 3'b111); req_valid = 3'b010;
    run_txn(0, 8, 1, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== 1 || a !== 32'h2000) begin n_fail++; $display("FAIL burst8_gnt got=%0d addr=%h want=1/2000", g, a); end
    n_checks++; if (len !== 8'd7) begin n_fail++; $display("FAIL burst8_len got=%0d want=7", len); end
    n_checks++; if (beats !== 8 || lc !== 1 || lp !== 8) begin n_fail++; $display("FAIL burst8_beats got=%0d last=%0d at=%0d want=8/1/8", beats, lc, lp); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL burst8_protocol got=%0d errors want=0", bad); end
    m_ptr = 2;
  endtask

  task automatic test_round_robin();
    int g, beats, lc, lp, bad, w, e; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    wr_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, 3'b010);
    req_valid = '1;
    for (int n = 0; n < 6; n++) begin
      e = exp_grant();
      run_txn(0, 1, 0, 0, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d want=%0d", n, g, e); end
      n_checks++; if (w !== 0 || bad !== 0) begin n_fail++; $display("FAIL rr_b2b[%0d] wait=%0d bad=%0d want=0/0", n, w, bad); end
      m_ptr = (e + 1) % NREQ;
    end
    req_valid = '0;
  endtask

  task automatic test_wr_block();
    int g, beats, lc, lp, bad, w, e, blocked; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    wr_addr = 32'h3004; wr_busy = 1'b1;
    set_req(0, 32'h3008, 3'b010); set_req(1, 32'h4000, 3'b010); req_valid = 3'b011;
    e = exp_grant();
    run_txn(0, 1, 0, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== 1 || g !== e) begin n_fail++; $display("FAIL wrblk_first got=%0d want=1", g); end
    m_ptr = 2;
    blocked = 0;
    repeat (3) begin #1; if (req_rdy !== '0) blocked++; @(negedge aclk); #1; end
    n_checks++; if (blocked !== 0) begin n_fail++; $display("FAIL wrblk_hold got=%0d grants want=0", blocked); end
    wr_busy = 1'b0;
    e = exp_grant();
    run_txn(0, 1, 0, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== e || a !== 32'h3008) begin n_fail++; $display("FAIL wrblk_release got=%0d addr=%h want=%0d/3008", g, a, e); end
    m_ptr = 1;
  endtask

  task automatic test_ar_stall();
    int g, beats, lc, lp, bad, w; logic [31:0] a, ea; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    ea = $urandom;
    set_req(2, ea, 3'b000); req_valid = 3'b111;
    m_ptr = 1;
    set_req(0, $urandom, 3'b010); set_req(1, $urandom, 3'b001);
    req_valid = 3'b100;
    run_txn(5, 1, 0, 0, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== 2 || a !== ea || id !== 4'd2) begin n_fail++; $display("FAIL stall_grant got=%0d addr=%h id=%0d want=2/%h/2", g, a, id, ea); end
    n_checks++; if (len !== 8'd0 || sz !== 3'd0) begin n_fail++; $display("FAIL stall_len_size got=%0d/%0d want=0/0", len, sz); end
    n_checks++; if (bad !== 0 || beats !== 1) begin n_fail++; $display("FAIL stall_stability bad=%0d beats=%0d want=0/1", bad, beats); end
    req_valid = '0;
    m_ptr = 0;
  endtask

  task automatic test_early_last();
    int g, beats, lc, lp, bad, w, e; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    set_req(1, 32'h6000, 3'b111); req_valid = 3'b010;
    run_txn(1, 2, 0, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== 1 || len !== 8'd7 || beats !== 2 || lc !== 1) begin
      n_fail++; $display("FAIL early_last got gnt=%0d len=%0d beats=%0d last=%0d want=1/7/2/1", g, len, beats, lc); end
    m_ptr = 2;
    set_req(0, 32'h6100, 3'b010); req_valid = 3'b001;
    e = exp_grant();
    run_txn(0, 1, 0, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== e || w !== 0 || bad !== 0) begin n_fail++; $display("FAIL early_next got=%0d wait=%0d bad=%0d want=%0d/0/0", g, w, bad, e); end
    m_ptr = 1;
  endtask

  task automatic test_reset_mid_burst();
    int g, beats, lc, lp, bad, w, e; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz;
    set_req(1, 32'h5000, 3'b111); req_valid = 3'b010;
    #1;
    n_checks++; if (req_rdy !== 3'b010) begin n_fail++; $display("FAIL mid_grant got=%b want=010", req_rdy); end
    @(negedge aclk); #1;
    req_valid = 3'b000;
    axi_arready = 1'b1;
    @(negedge aclk); #1;
    axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rlast = 1'b0;
    repeat (3) begin axi_rdata = $urandom; @(negedge aclk); #1; end
    set_req(0, 32'h7000, 3'b010); set_req(2, 32'h8000, 3'b010); req_valid = 3'b101;
    aresetn = 1'b0;
    #1;
    n_checks++; if ({axi_arvalid, axi_rready, ret_valid, ret_last, req_rdy} !== '0) begin
      n_fail++; $display("FAIL mid_rst_ctrl got=%b want=0", {axi_arvalid, axi_rready, ret_valid, ret_last, req_rdy}); end
    n_checks++; if ({axi_araddr, axi_arid, axi_arlen, axi_arsize} !== '0) begin
      n_fail++; $display("FAIL mid_rst_fields got=%h want=0", {axi_araddr, axi_arid, axi_arlen, axi_arsize}); end
    req_valid = '0;
    @(negedge aclk); #1;
    aresetn = 1'b1;
    m_ptr = 0;
    @(negedge aclk); #1;
    n_checks++; if (ret_valid !== '0) begin n_fail++; $display("FAIL mid_no_ret got=%b want=0", ret_valid); end
    axi_rvalid = 1'b0;
    req_valid = 3'b101;
    e = exp_grant();
    run_txn(0, 1, 0, 1, 0, g, a, id, len, sz, beats, lc, lp, bad, w);
    n_checks++; if (g !== e || a !== 32'h7000 || bad !== 0) begin n_fail++; $display("FAIL mid_after got=%0d addr=%h bad=%0d want=%0d/7000/0", g, a, bad, e); end
    m_ptr = (e + 1) % NREQ;
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, beats, lc, lp, bad, w, e, nb; logic [31:0] a; logic [IDW-1:0] id; logic [7:0] len; logic [2:0] sz, t;
    logic [2:0] tt [5];
    tt = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};
    for (int it = 0; it < 30; it++) begin
      wr_addr = $urandom;
      wr_busy = 1'($urandom_range(1, 0));
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(3, 0) == 0) ? {wr_addr[31:4], 4'($urandom)} : $urandom, tt[$urandom_range(4, 0)]);
      req_valid = 3'($urandom_range(7, 1));
      if (exp_grant() < 0) begin
        #1;
        n_checks++; if (req_rdy !== '0) begin n_fail++; $display("FAIL rnd_blocked[%0d] got=%b want=0", it, req_rdy); end
        wr_busy = 1'b0;
      end
      e  = exp_grant();
      t  = req_type[3*e +: 3];
      nb = int'(m_len(t)) + 1;
      run_txn($urandom_range(3, 0), nb, 2, 1, 1'($urandom_range(1, 0)), g, a, id, len, sz, beats, lc, lp, bad, w);
      n_checks++; if (g !== e || id !== IDW'(e)) begin n_fail++; $display("FAIL rnd_gnt[%0d] got=%0d id=%0d want=%0d", it, g, id, e); end
      n_checks++; if (a !== req_addr[32*e +: 32]) begin n_fail++; $display("FAIL rnd_addr[%0d] got=%h want=%h", it, a, req_addr[32*e +: 32]); end
      n_checks++; if (len !== m_len(t) || sz !== m_size(t)) begin n_fail++; $display("FAIL rnd_len_size[%0d] got=%0d/%0d want=%0d/%0d", it, len, sz, m_len(t), m_size(t)); end
      n_checks++; if (beats !== nb || lc !== 1 || lp !== nb || bad !== 0) begin
        n_fail++; $display("FAIL rnd_beats[%0d] got=%0d last=%0d at=%0d bad=%0d want=%0d/1/%0d/0", it, beats, lc, lp, bad, nb, nb); end
      m_ptr = (e + 1) % NREQ;
    end
    req_valid = '0;
    wr_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge aclk); #1;
    test_reset();
    test_single_word();
    test_burst8();
    test_round_robin();
    test_wr_block();
    test_ar_stall();
    test_early_last();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
